mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 142 ++++++++++++++
 tb/tb_mem_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage -- memory access stage of the pipeline.
// Latches the EX/MEM operation. ALU ops write back one cycle later.
// Loads and stores run a request/acknowledge bus transaction.
// While that transaction is running, the stage stalls upstream.
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   ex_*               operation from EX (ignored while BUSY)
//   mem_busy           stall request to IF/ID/EX
//   mem_err            one-cycle pulse when a bus access times out
//   wb_data/_write_reg/_reg_write   registered write-back
//   bus_req/we/addr/wdata/be        memory request, held until ack or abort
//   bus_ack/bus_rdata               single-cycle completion + read data
module mem_stage #(
  parameter int BUS_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_mem_data,
  input  logic        ex_load_byte,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [4:0]  ex_write_reg,
  output logic        mem_busy,
  output logic        mem_err,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_write_reg,
  output logic        wb_reg_write,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [7:0] TMO_LAST = 8'(BUS_TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  // EX/MEM register
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_byte;
  logic        r_rw;
  logic        r_rd;
  logic        r_wr;
  logic [4:0]  r_reg;

  logic        w_busy;
  logic        w_load;
  logic [1:0]  w_lane;
  logic [3:0]  w_be_byte;
  logic [31:0] w_shift;
  logic [7:0]  w_rbyte;
  logic [31:0] w_load_data;

  assign w_busy    = (r_state == S_BUSY);
  // A write wins when read and write are both set.
  assign w_load    = r_rd & ~r_wr;
  assign w_lane    = r_addr[1:0];
  assign w_be_byte = 4'b0001 << w_lane;
  assign w_shift   = bus_rdata >> {w_lane, 3'b000};
  assign w_rbyte   = w_shift[7:0];
  assign w_load_data = r_byte ? {{24{w_rbyte[7]}}, w_rbyte} : bus_rdata;

  assign mem_busy  = w_busy;
  assign bus_req   = w_busy;
  // Bus fields are held at zero outside a transaction.
  // Because of this, reset leaves every output at zero.
  assign bus_we    = w_busy & r_wr;
  assign bus_addr  = w_busy ? {r_addr[31:2], 2'b00} : 32'h0;
  assign bus_be    = w_busy ? (r_byte ? w_be_byte : 4'b1111) : 4'b0000;
  assign bus_wdata = (w_busy & r_wr) ? (r_byte ? {4{r_data[7:0]}} : r_data) : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_byte       <= 1'b0;
      r_rw         <= 1'b0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_reg        <= '0;
      wb_data      <= '0;
      wb_write_reg <= '0;
      wb_reg_write <= 1'b0;
      mem_err      <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_addr <= ex_result;
          r_data <= ex_mem_data;
          r_byte <= ex_load_byte;
          r_rw   <= ex_reg_write;
          r_rd   <= ex_mem_read;
          r_wr   <= ex_mem_write;
          r_reg  <= ex_write_reg;
          if (ex_mem_read | ex_mem_write) begin
            r_state      <= S_BUSY;
            r_cnt        <= '0;
            wb_reg_write <= 1'b0;
          end else begin
            wb_data      <= ex_result;
            wb_write_reg <= ex_write_reg;
            wb_reg_write <= ex_reg_write;
          end
        end
        S_BUSY: begin
          // ex_* inputs are not sampled here; upstream holds the next op.
          // That op is latched on the first IDLE edge, without a bubble.
          if (bus_ack) begin
            r_state <= S_IDLE;
            if (w_load) begin
              wb_data      <= w_load_data;
              wb_write_reg <= r_reg;
              wb_reg_write <= r_rw;
            end else begin
              wb_reg_write <= 1'b0;
            end
          end else if (r_cnt == TMO_LAST) begin
            r_state      <= S_IDLE;
            mem_err      <= 1'b1;
            wb_reg_write <= 1'b0;
          end else begin
            r_cnt        <= r_cnt + 8'd1;
            wb_reg_write <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_result, ex_mem_data;
  logic        ex_load_byte, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_write_reg;
  logic        mem_busy, mem_err, wb_reg_write;
  logic [31:0] wb_data;
  logic [4:0]  wb_write_reg;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int npass = 0;
  int ntot  = 0;

  mem_stage #(.BUS_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ex_result(ex_result), .ex_mem_data(ex_mem_data), .ex_load_byte(ex_load_byte),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_write_reg(ex_write_reg),
    .mem_busy(mem_busy), .mem_err(mem_err),
    .wb_data(wb_data), .wb_write_reg(wb_write_reg), .wb_reg_write(wb_reg_write),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] exp_data;
    logic [4:0]  exp_reg;
    logic        exp_rw;
  } alu_vec_t;

  alu_vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] res, input logic [31:0] data, input logic byt,
                        input logic rw, input logic rd, input logic wr, input logic [4:0] rg);
    ex_result = res; ex_mem_data = data; ex_load_byte = byt;
    ex_reg_write = rw; ex_mem_read = rd; ex_mem_write = wr; ex_write_reg = rg;
  endtask

  task automatic nop();
    set_op(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    int busy_n, err_n, wr_n;
    vecs[0] = '{32'h0000_1234, 5'd5,  1'b1, 32'h0000_1234, 5'd5,  1'b1};
    vecs[1] = '{32'hFFFF_FFFF, 5'd31, 1'b1, 32'hFFFF_FFFF, 5'd31, 1'b1};
    vecs[2] = '{32'hDEAD_0001, 5'd12, 1'b0, 32'hDEAD_0001, 5'd12, 1'b0};
    vecs[3] = '{32'h0000_0000, 5'd1,  1'b1, 32'h0000_0000, 5'd1,  1'b1};

    rst = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    set_op(32'h1111_1111, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9);
    step(); step();
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_reg", 32'(wb_write_reg), 32'h0);
    chk("rst_wb_rw", 32'(wb_reg_write), 32'h0);
    chk("rst_err", 32'(mem_err), 32'h0);
    chk("rst_busy", 32'(mem_busy), 32'h0);
    chk("rst_req", 32'(bus_req), 32'h0);
    rst = 1'b1;

    // Single-cycle ALU ops.
    for (int i = 0; i < 4; i++) begin
      set_op(vecs[i].res, 32'h0, 1'b0, vecs[i].rw, 1'b0, 1'b0, vecs[i].rd);
      step();
      chk($sformatf("alu%0d_data", i), wb_data, vecs[i].exp_data);
      chk($sformatf("alu%0d_reg", i), 32'(wb_write_reg), 32'(vecs[i].exp_reg));
      chk($sformatf("alu%0d_rw", i), 32'(wb_reg_write), 32'(vecs[i].exp_rw));
      chk($sformatf("alu%0d_busy", i), 32'(mem_busy), 32'h0);
    end

    // LB 0x103; ack arrives in the second BUSY cycle. An ALU op waits behind it.
    set_op(32'h0000_0103, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
    step();
    chk("lb_busy", 32'(mem_busy), 32'h1);
    chk("lb_addr", bus_addr, 32'h0000_0100);
    chk("lb_be", 32'(bus_be), 32'h8);
    chk("lb_we", 32'(bus_we), 32'h0);
    chk("lb_rw_cleared", 32'(wb_reg_write), 32'h0);
    set_op(32'h0000_0055, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9);
    step();
    chk("lb_busy2", 32'(mem_busy), 32'h1);
    chk("lb_nowrite_busy", 32'(wb_reg_write), 32'h0);
    bus_ack = 1'b1; bus_rdata = 32'h80FF_0000;
    step();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    chk("lb_idle", 32'(mem_busy), 32'h0);
    chk("lb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_reg", 32'(wb_write_reg), 32'd3);
    chk("lb_rw", 32'(wb_reg_write), 32'h1);
    step();
    chk("after_lb_data", wb_data, 32'h0000_0055);
    chk("after_lb_reg", 32'(wb_write_reg), 32'd9);
    chk("after_lb_rw", 32'(wb_reg_write), 32'h1);
    nop(); step();

    // SB 0x201, data 0xA5.
    set_op(32'h0000_0201, 32'h0000_00A5, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0);
    step(); nop();
    chk("sb_we", 32'(bus_we), 32'h1);
    chk("sb_be", 32'(bus_be), 32'h2);
    chk("sb_wdata", bus_wdata, 32'hA5A5_A5A5);
    chk("sb_addr", bus_addr, 32'h0000_0200);
    bus_ack = 1'b1; step(); bus_ack = 1'b0;
    chk("sb_idle", 32'(mem_busy), 32'h0);
    chk("sb_rw", 32'(wb_reg_write), 32'h0);
    step();
    chk("sb_rw2", 32'(wb_reg_write), 32'h0);

    // SW 0x300.
    set_op(32'h0000_0300, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4);
    step(); nop();
    chk("sw_be", 32'(bus_be), 32'hF);
    chk("sw_wdata", bus_wdata, 32'h1234_5678);
    bus_ack = 1'b1; step(); bus_ack = 1'b0;
    chk("sw_rw", 32'(wb_reg_write), 32'h0);

    // Misaligned LW uses the aligned address.
    set_op(32'h0000_1006, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7);
    step(); nop();
    chk("lw_addr", bus_addr, 32'h0000_1004);
    chk("lw_be", 32'(bus_be), 32'hF);
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF; step(); bus_ack = 1'b0;
    chk("lw_data", wb_data, 32'hDEAD_BEEF);
    chk("lw_reg", 32'(wb_write_reg), 32'd7);
    chk("lw_rw", 32'(wb_reg_write), 32'h1);
    step();
    chk("lw_rw_once", 32'(wb_reg_write), 32'h0);

    // Read and write both set: treated as a store.
    set_op(32'h0000_0400, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1, 1'b1, 5'd6);
    step(); nop();
    chk("rw_both_we", 32'(bus_we), 32'h1);
    bus_ack = 1'b1; step(); bus_ack = 1'b0;
    chk("rw_both_rw", 32'(wb_reg_write), 32'h0);

    // Ack while IDLE has no effect.
    bus_ack = 1'b1;
    set_op(32'h0000_0077, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2);
    step(); bus_ack = 1'b0; nop();
    chk("idle_ack_data", wb_data, 32'h0000_0077);
    chk("idle_ack_busy", 32'(mem_busy), 32'h0);

    // LW with no ack: request for 8 cycles, then abort with a single error pulse.
    set_op(32'h0000_0500, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd8);
    step(); nop();
    busy_n = 0; err_n = 0; wr_n = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus_req) busy_n++;
      if (mem_err) err_n++;
      if (wb_reg_write) wr_n++;
      step();
    end
    chk("tmo_req_cycles", 32'(busy_n), 32'd8);
    chk("tmo_err_pulses", 32'(err_n), 32'd1);
    chk("tmo_no_write", 32'(wr_n), 32'd0);
    chk("tmo_idle", 32'(mem_busy), 32'h0);

    // Reset while BUSY, then a late ack arrives.
    set_op(32'h0000_0600, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd10);
    step(); nop(); step();
    chk("rstb_busy_before", 32'(bus_req), 32'h1);
    rst = 1'b0; step(); rst = 1'b1;
    chk("rstb_req", 32'(bus_req), 32'h0);
    bus_ack = 1'b1; bus_rdata = 32'h1234_ABCD; step(); bus_ack = 1'b0;
    chk("rstb_rw", 32'(wb_reg_write), 32'h0);
    chk("rstb_data", wb_data, 32'h0);
    chk("rstb_reg", 32'(wb_write_reg), 32'h0);
    chk("rstb_addr", bus_addr, 32'h0);
    chk("rstb_be", 32'(bus_be), 32'h0);
    chk("rstb_err", 32'(mem_err), 32'h0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
